// File: rtl/neuron_layer_pkg.sv
// Shared types and defaults for the neuron-layer driver.
// State encoding, default geometry and an index-width helper.
package neuron_layer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_EMIT
    } state_t;

    localparam int DEF_W       = 8;
    localparam int DEF_NI      = 2;
    localparam int DEF_NO      = 2;
    localparam int DEF_TIMEOUT = 64;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_out_serializer.sv
// Result capture register and EMIT-phase valid/ready/last sequencer.
// Captures all NO words on load, then streams word 0 .. NO-1.
module layer_out_serializer
    import neuron_layer_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int NO = DEF_NO
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [NO*W-1:0] res_bus,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic          done
);

    localparam int IW = idx_w(NO);

    logic [NO*W-1:0] cap;
    logic [IW-1:0]   idx;
    logic            valid;
    logic            at_last;

    assign at_last   = (idx == IW'(NO - 1));
    assign out_valid = valid;
    assign out_last  = valid & at_last;
    assign done      = valid & out_ready & at_last;
    assign out_data  = valid ? cap[int'(idx)*W +: W] : '0;

    // Capture on load, then advance one word per accepted transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap   <= '0;
            idx   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            cap   <= res_bus;
            idx   <= '0;
            valid <= 1'b1;
        end else if (valid && out_ready) begin
            if (at_last) begin
                valid <= 1'b0;
                idx   <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/neuron_layer_driver.sv
// Initiator side of the neuron-layer req/ack protocol.
// Optional REQ watchdog enabled by LAYER_DRV_TIMEOUT_EN.
module neuron_layer_driver
    import neuron_layer_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int NI      = DEF_NI,
    parameter int NO      = DEF_NO,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    output logic                 mem_we,
    output logic [idx_w(NI)-1:0] mem_addr,
    output logic [W-1:0]         mem_wdata,
    output logic                 req,
    input  logic                 ack,
    input  logic [NO*W-1:0]      res_bus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int AW = idx_w(NI);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] cnt;
    logic          accept;
    logic          ser_load;
    logic          ser_done;
    logic          timed_out;

    assign accept   = in_valid & in_ready;
    assign ser_load = (state == S_REQ) & ack;
    assign busy     = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state decode; ack wins over a same-cycle timeout.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (accept) state_nx = (NI == 1) ? S_REQ : S_LOAD;
            S_LOAD: if (accept && cnt == AW'(NI - 1)) state_nx = S_REQ;
            S_REQ: begin
                if (ack)            state_nx = S_EMIT;
                else if (timed_out) state_nx = S_IDLE;
            end
            S_EMIT: if (ser_done) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Registered handshake outputs, memory write port and word counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req       <= 1'b0;
        end else begin
            in_ready <= (state_nx == S_IDLE) || (state_nx == S_LOAD);
            req      <= (state_nx == S_REQ);
            mem_we   <= accept;
            if (accept) begin
                mem_addr  <= cnt;
                mem_wdata <= in_data;
                cnt       <= (state_nx == S_LOAD) ? cnt + 1'b1 : '0;
            end
        end
    end

`ifdef LAYER_DRV_TIMEOUT_EN
    localparam int TW = idx_w(TIMEOUT + 1);

    logic [TW-1:0] tcnt;

    assign timed_out = (state == S_REQ) && (tcnt == TW'(TIMEOUT - 1));

    // REQ watchdog and sticky abort flag, cleared by the next vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt        <= '0;
            err_timeout <= 1'b0;
        end else begin
            tcnt <= (state == S_REQ) ? tcnt + 1'b1 : '0;
            if (state == S_IDLE && accept)
                err_timeout <= 1'b0;
            else if (timed_out && !ack)
                err_timeout <= 1'b1;
        end
    end
`else
    assign timed_out   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    layer_out_serializer #(
        .W  (W),
        .NO (NO)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .res_bus   (res_bus),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_neuron_layer_driver.sv
// Self-checking bench for neuron_layer_driver (W=8, NI=2, NO=2).
// Scoreboard queues hold expected memory writes and result words.
module tb_neuron_layer_driver;

    localparam int W  = 8;
    localparam int NI = 2;
    localparam int NO = 2;
    localparam int AW = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_data = '0;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_wdata;
    logic            req;
    logic            ack = 1'b0;
    logic [NO*W-1:0] res_bus = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic            busy;
    logic            err_timeout;

    int checks = 0;
    int failures = 0;

    logic [AW+W-1:0] exp_mem[$];
    logic [W:0]      exp_out[$];

    neuron_layer_driver #(
        .W(W), .NI(NI), .NO(NO), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .req(req), .ack(ack), .res_bus(res_bus),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every write and every result transfer is popped and compared.
    always @(negedge clk) begin
        logic [AW+W-1:0] em;
        logic [W:0]      eo;
        if (rst === 1'b1) begin
            if (mem_we) begin
                checks++;
                if (exp_mem.size() == 0) begin
                    failures++;
                    $display("FAIL mem_unexpected got=%h", {mem_addr, mem_wdata});
                end else begin
                    em = exp_mem.pop_front();
                    if ({mem_addr, mem_wdata} !== em) begin
                        failures++;
                        $display("FAIL mem_write got=%h exp=%h", {mem_addr, mem_wdata}, em);
                    end
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_out.size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected got=%h", {out_data, out_last});
                end else begin
                    eo = exp_out.pop_front();
                    if ({out_data, out_last} !== eo) begin
                        failures++;
                        $display("FAIL out_word got=%h exp=%h", {out_data, out_last}, eo);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [W-1:0] d, output bit ok);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        exp_mem.push_back({a, d});
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        @(posedge clk);
        #2;
    endtask

    task automatic send_vec(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        bit ok0, ok1;
        send_word(1'b0, a, ok0);
        send_word(1'b1, b, ok1);
        in_valid = 1'b0;
        ok = ok0 & ok1;
    endtask

    task automatic run_layer(input logic [NO*W-1:0] r, input int delay, output bit ok);
        int n = 0;
        while (!req && n < 30) begin
            tick();
            n++;
        end
        ok = req;
        if (req) begin
            repeat (delay) tick();
            res_bus = r;
            ack = 1'b1;
            for (int k = 0; k < NO; k++)
                exp_out.push_back({r[k*W +: W], k == NO - 1});
            tick();
            ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== '0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", req); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_timeout); end
        rst = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        bit ok;
        int n = 0;
        out_ready = 1'b1;
        send_vec(8'h03, 8'h05, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_send got=0 exp=1"); end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                res_bus = 16'h1122;
                ack = 1'b1;
                exp_out.push_back({8'h22, 1'b0});
                exp_out.push_back({8'h11, 1'b1});
            end
            @(negedge clk);
            checks++; if (req !== 1'b1) begin failures++; $display("FAIL basic_req_hi cyc=%0d got=%b exp=1", i, req); end
            tick();
        end
        ack = 1'b0;
        @(negedge clk);
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL basic_req_lo got=%b exp=0", req); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            failures++; $display("FAIL basic_first_out got=%b/%h exp=1/22", out_valid, out_data);
        end
        tick();
        while ((busy || exp_out.size() != 0) && n < 40) begin tick(); n++; end
        checks++; if (busy || exp_out.size() != 0 || exp_mem.size() != 0) begin
            failures++; $display("FAIL basic_drain got=%0d/%0d exp=0/0", exp_out.size(), exp_mem.size());
        end
    endtask

    task automatic test_in_backpressure();
        bit ok;
        int n = 0;
        out_ready = 1'b1;
        send_vec(8'h01, 8'h02, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_send got=0 exp=1"); end
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_req got=%b exp=0", in_ready); end
            tick();
        end
        run_layer(16'h3344, 0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_req got=0 exp=1"); end
        while (busy && n < 20) begin
            @(negedge clk);
            if (busy) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_emit got=%b exp=0", in_ready); end
            end
            tick();
            n++;
        end
        send_word(1'b0, 8'hAA, ok);
        send_word(1'b1, 8'hBB, ok);
        in_valid = 1'b0;
        run_layer(16'h5A6B, 2, ok);
        n = 0;
        while ((busy || exp_out.size() != 0) && n < 40) begin tick(); n++; end
        checks++; if (busy || exp_out.size() != 0 || exp_mem.size() != 0) begin
            failures++; $display("FAIL bp_drain got=%0d/%0d exp=0/0", exp_out.size(), exp_mem.size());
        end
    endtask

    task automatic test_out_stall();
        bit ok;
        int n = 0;
        out_ready = 1'b0;
        send_vec(8'h44, 8'h45, ok);
        run_layer(16'h5566, 1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_req got=0 exp=1"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h66 || out_last !== 1'b0) begin
                failures++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%b exp=1/66/0", i, out_valid, out_data, out_last);
            end
            tick();
        end
        out_ready = 1'b1;
        while ((busy || exp_out.size() != 0) && n < 40) begin tick(); n++; end
        checks++; if (busy || exp_out.size() != 0 || exp_mem.size() != 0) begin
            failures++; $display("FAIL stall_drain got=%0d/%0d exp=0/0", exp_out.size(), exp_mem.size());
        end
    endtask

    task automatic test_ack_idle();
        bit ok;
        int n = 0;
        out_ready = 1'b1;
        res_bus = 16'hDEAD;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        res_bus = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL idle_ack got=%b/%b exp=0/0", out_valid, busy);
            end
            tick();
        end
        send_vec(8'h0C, 8'h0D, ok);
        run_layer(16'h1357, 0, ok);
        while ((busy || exp_out.size() != 0) && n < 40) begin tick(); n++; end
        checks++; if (busy || exp_out.size() != 0 || exp_mem.size() != 0) begin
            failures++; $display("FAIL idle_drain got=%0d/%0d exp=0/0", exp_out.size(), exp_mem.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        out_ready = 1'b1;
        send_vec(8'h71, 8'h72, ok);
        repeat (2) tick();
        checks++; if (req !== 1'b1 || exp_mem.size() != 0) begin
            failures++; $display("FAIL mid_pre got=%b/%0d exp=1/0", req, exp_mem.size());
        end
        rst = 1'b0;
        #1;
        checks++; if (req !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL mid_async got=%b%b%b exp=000", req, busy, out_valid);
        end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        send_vec(8'h07, 8'h08, ok);
        run_layer(16'h99AA, 1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_req got=0 exp=1"); end
        while ((busy || exp_out.size() != 0) && n < 40) begin tick(); n++; end
        checks++; if (busy || exp_out.size() != 0 || exp_mem.size() != 0) begin
            failures++; $display("FAIL mid_drain got=%0d/%0d exp=0/0", exp_out.size(), exp_mem.size());
        end
    endtask

`ifdef LAYER_DRV_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n = 0;
        out_ready = 1'b1;
        send_vec(8'h31, 8'h32, ok);
        while (req && n < 40) begin n++; tick(); end
        checks++; if (n != 8) begin failures++; $display("FAIL to_req_cycles got=%0d exp=8", n); end
        checks++; if (err_timeout !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL to_abort got=%b/%b/%b exp=1/0/0", err_timeout, out_valid, busy);
        end
        repeat (3) tick();
        checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", err_timeout); end
        send_word(1'b0, 8'h21, ok);
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", err_timeout); end
        send_word(1'b1, 8'h22, ok);
        in_valid = 1'b0;
        run_layer(16'h4242, 0, ok);
        n = 0;
        while ((busy || exp_out.size() != 0) && n < 40) begin tick(); n++; end
        checks++; if (busy || exp_out.size() != 0 || exp_mem.size() != 0) begin
            failures++; $display("FAIL to_drain got=%0d/%0d exp=0/0", exp_out.size(), exp_mem.size());
        end
    endtask
`endif

    task automatic test_back_to_back();
        bit ok;
        int n = 0;
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            send_vec(W'($urandom), W'($urandom), ok);
            checks++; if (!ok) begin failures++; $display("FAIL b2b_send v=%0d got=0 exp=1", v); end
            run_layer((NO*W)'($urandom), $urandom_range(0, 3), ok);
        end
        while ((busy || exp_out.size() != 0) && n < 40) begin tick(); n++; end
        checks++; if (busy || exp_out.size() != 0 || exp_mem.size() != 0) begin
            failures++; $display("FAIL b2b_drain got=%0d/%0d exp=0/0", exp_out.size(), exp_mem.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_in_backpressure();
        test_out_stall();
        test_ack_idle();
        test_reset_mid();
`ifdef LAYER_DRV_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
